data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//   Responder side of the single-cycle CPU's data-memory interface: answers memwrite/aluout/writedata
//   with readdata in the same cycle. Backs a word-addressed data RAM plus a small memory-mapped I/O
//   page: console TX FIFO with valid/ready drain port, free-running cycle counter, scratch register.
//   Sits beside the cpu top in the system wrapper; instruction memory is a separate block.
// PARAMETERS
//   DEPTH_WORDS  64            data RAM size in 32-bit words (power of two)
//   FIFO_DEPTH   4             console TX FIFO entries (power of two, >=2)
//   IO_BASE      32'hFFFF_FF00 base of 256-byte I/O page (low 8 bits must be zero)
// PORTS
//   clk        in   1   system clock, all state updates on posedge
//   reset      in   1   asynchronous, active-low reset
//   memwrite   in   1   CPU store strobe for current cycle
//   aluout     in   32  CPU byte address; bits[1:0] ignored (word access only)
//   writedata  in   32  CPU store data
//   readdata   out  32  load data, combinational from aluout, valid same cycle
//   con_data   out  8   console byte at FIFO head
//   con_valid  out  1   FIFO non-empty
//   con_ready  in   1   console sink accepts con_data this cycle
// BEHAVIOUR
//   Decode: aluout[31:8]==IO_BASE[31:8] -> I/O page; else RAM, index aluout[$clog2(DEPTH_WORDS)+1:2]
//     (upper bits ignored, addresses alias modulo RAM size).
//   RAM: read combinational; write at posedge when memwrite & RAM region. Contents not reset.
//   readdata forced to 0 while reset low; otherwise RAM word or I/O register below.
//   I/O offsets (aluout[7:0]): 0x00 CON_TX  W: push writedata[7:0]; R: 0
//     0x04 STATUS R: {16'b0, count[7:0], 5'b0, ovf, full, empty}; W: writedata[2]=1 clears ovf
//     0x08 CYCLE  R: counter value before edge; W: loads writedata (write beats increment)
//     0x0C SCRATCH R/W 32-bit. Other offsets: read 0, writes ignored.
//   CYCLE: +1 every clock out of reset, wraps 32'hFFFF_FFFF -> 0.
//   FIFO: pop on con_valid & con_ready; con_data = head, registered storage, no bubble.
//     Push on CON_TX write accepted if !full OR pop in same cycle (count unchanged, order kept).
//     Push when full and no pop: byte dropped, ovf set (sticky until cleared or reset).
//     Simultaneous push and ovf-clear write impossible (one address/cycle). Pointers wrap mod FIFO_DEPTH.
//     con_data undefined-but-stable when empty; sink must qualify with con_valid.
//   Reset (async assert, sync-safe deassert by system): FIFO empty, count 0, ovf 0, CYCLE 0,
//     SCRATCH 0, con_valid 0. Reset mid-drain discards all queued bytes; RAM untouched.
//   Latency: load 0 cycles (combinational); store/push visible to next-cycle reads.
// STRUCTURE
//   Package mem_map_pkg: IO_BASE default, offset localparams (OFF_CON_TX, OFF_STATUS, OFF_CYCLE,
//     OFF_SCRATCH), STATUS bit positions.
//   Sub-module con_tx_fifo (params WIDTH=8, DEPTH): push/pop/full/empty/count/ovf, async active-low reset.
//   Top holds decode, RAM array, CYCLE, SCRATCH, readdata mux.
// TESTING
//   Reset low 2 cycles, then high: readdata=0 during reset; con_valid=0, STATUS read 32'h0000_0001.
//   Store 32'hDEAD_BEEF @0x10, load @0x10 and alias @0x10+4*DEPTH_WORDS -> both 32'hDEAD_BEEF.
//   con_ready=0, write 'A','B','C','D','E' to CON_TX -> STATUS = 32'h0000_0406 (count 4, full, ovf);
//     raise con_ready -> con_data 'A','B','C','D' on 4 consecutive cycles, then con_valid=0.
//   FIFO full, con_ready=1 and CON_TX write same cycle -> pop 'A', push accepted, count stays 4, no ovf.
//   Write CYCLE=32'hFFFF_FFFE, read next two cycles -> 32'hFFFF_FFFF then 32'h0000_0000.
//   Queue 3 bytes, pulse reset low mid-drain -> con_valid=0 immediately, STATUS=32'h0000_0001 after.

Source files
------------

// File: rtl/mem_map_pkg.sv
// Memory map of the data-memory responder: default I/O page base, I/O register
// offsets and STATUS register bit positions.
package mem_map_pkg;

   localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_FF00;

   // I/O register byte offsets within the 256-byte page
   localparam logic [7:0] OFF_CON_TX  = 8'h00;
   localparam logic [7:0] OFF_STATUS  = 8'h04;
   localparam logic [7:0] OFF_CYCLE   = 8'h08;
   localparam logic [7:0] OFF_SCRATCH = 8'h0C;

   // STATUS register layout
   localparam int unsigned STAT_EMPTY_BIT = 0;
   localparam int unsigned STAT_FULL_BIT  = 1;
   localparam int unsigned STAT_OVF_BIT   = 2;
   localparam int unsigned STAT_COUNT_LSB = 8;
   localparam int unsigned STAT_COUNT_W   = 8;

endpackage

// File: rtl/con_tx_fifo.sv
// Console TX FIFO with valid/ready drain port and sticky overflow flag.
//   clk, rst_n      clock, async active-low reset
//   push_i, data_i  push request and byte
//   ready_i         sink accepts head this cycle (pop when also non-empty)
//   ovf_clr_i       clear sticky overflow
//   data_o/valid_o  head entry / non-empty
//   full_o, empty_o, count_o, ovf_o  occupancy and overflow status
module con_tx_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     ready_i,
   input  logic                     ovf_clr_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     valid_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     ovf_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             pop, push_ok, full, empty;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign pop   = ~empty & ready_i;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign push_ok = push_i & (~full | pop);

   // Storage is not reset; the head is only meaningful while non-empty.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end

   always_comb begin
      count_d = count_q;
      ovf_d   = ovf_q;
      case ({push_ok, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      if (ovf_clr_i)             ovf_d = 1'b0;
      else if (push_i & ~push_ok) ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign valid_o = ~empty;
   assign full_o  = full;
   assign empty_o = empty;
   assign count_o = count_q;
   assign ovf_o   = ovf_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the single-cycle CPU: word RAM plus an I/O page
// holding console TX FIFO, free-running cycle counter and a scratch register.
//   clk, reset           clock, async active-low reset
//   memwrite, aluout, writedata   CPU store strobe, byte address, store data
//   readdata             combinational load data for aluout
//   con_data, con_valid, con_ready   console drain port
module data_mem_responder
   import mem_map_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 64,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter logic [31:0] IO_BASE     = IO_BASE_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] aluout,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic [7:0]  con_data,
   output logic        con_valid,
   input  logic        con_ready
);

   localparam int unsigned AW    = $clog2(DEPTH_WORDS);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]      ram_q [DEPTH_WORDS];
   logic [31:0]      cycle_q, cycle_d;
   logic [31:0]      scratch_q, scratch_d;
   logic [31:0]      status;
   logic [AW-1:0]    ram_idx;
   logic [5:0]       io_word;
   logic             io_sel;
   logic             wr_con, wr_status, wr_cycle, wr_scratch;
   logic             fifo_full, fifo_empty, fifo_ovf;
   logic [CNT_W-1:0] fifo_count;
   logic [1:0]       unused_byte_lane;

   assign unused_byte_lane = aluout[1:0];

   // Address decode; RAM aliases modulo its size outside the I/O page.
   assign io_sel  = (aluout[31:8] == IO_BASE[31:8]);
   assign ram_idx = aluout[AW+1:2];
   assign io_word = aluout[7:2];

   assign wr_con     = memwrite & io_sel & (io_word == OFF_CON_TX[7:2]);
   assign wr_status  = memwrite & io_sel & (io_word == OFF_STATUS[7:2]);
   assign wr_cycle   = memwrite & io_sel & (io_word == OFF_CYCLE[7:2]);
   assign wr_scratch = memwrite & io_sel & (io_word == OFF_SCRATCH[7:2]);

   // Data RAM, contents survive reset.
   always_ff @(posedge clk) begin
      if (memwrite & ~io_sel) ram_q[ram_idx] <= writedata;
   end

   con_tx_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_con_tx_fifo (
      .clk       (clk),
      .rst_n     (reset),
      .push_i    (wr_con),
      .data_i    (writedata[7:0]),
      .ready_i   (con_ready),
      .ovf_clr_i (wr_status & writedata[STAT_OVF_BIT]),
      .data_o    (con_data),
      .valid_o   (con_valid),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .count_o   (fifo_count),
      .ovf_o     (fifo_ovf)
   );

   // A CYCLE store takes priority over the free-running increment.
   always_comb begin
      cycle_d   = wr_cycle   ? writedata : cycle_q + 32'd1;
      scratch_d = wr_scratch ? writedata : scratch_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cycle_q   <= '0;
         scratch_q <= '0;
      end else begin
         cycle_q   <= cycle_d;
         scratch_q <= scratch_d;
      end
   end

   always_comb begin
      status = '0;
      status[STAT_EMPTY_BIT] = fifo_empty;
      status[STAT_FULL_BIT]  = fifo_full;
      status[STAT_OVF_BIT]   = fifo_ovf;
      status[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);
   end

   // Load mux; held at zero while reset is asserted.
   always_comb begin
      readdata = '0;
      if (reset) begin
         if (io_sel) begin
            if      (io_word == OFF_STATUS[7:2])  readdata = status;
            else if (io_word == OFF_CYCLE[7:2])   readdata = cycle_q;
            else if (io_word == OFF_SCRATCH[7:2]) readdata = scratch_q;
            else                                  readdata = '0;
         end else begin
            readdata = ram_q[ram_idx];
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder.
module tb_data_mem_responder;

   localparam logic [31:0] IO      = 32'hFFFF_FF00;
   localparam logic [31:0] CON_TX  = IO + 32'h00;
   localparam logic [31:0] STATUS  = IO + 32'h04;
   localparam logic [31:0] CYCLE   = IO + 32'h08;
   localparam logic [31:0] SCRATCH = IO + 32'h0C;

   logic        clk = 1'b0;
   logic        reset;
   logic        memwrite;
   logic [31:0] aluout;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  con_data;
   logic        con_valid;
   logic        con_ready;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   data_mem_responder dut (
      .clk       (clk),
      .reset     (reset),
      .memwrite  (memwrite),
      .aluout    (aluout),
      .writedata (writedata),
      .readdata  (readdata),
      .con_data  (con_data),
      .con_valid (con_valid),
      .con_ready (con_ready)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      memwrite  = 1'b1;
      aluout    = addr;
      writedata = data;
      cyc();
      memwrite  = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      memwrite = 1'b0;
      aluout   = addr;
      #1;
      chk(tag, readdata, exp);
   endtask

   initial begin
      reset     = 1'b0;
      memwrite  = 1'b0;
      aluout    = 32'h10;
      writedata = '0;
      con_ready = 1'b0;

      // Reset for two cycles
      cyc();
      cyc();
      chk("rst_readdata", readdata, 32'h0);
      chk("rst_valid", {31'b0, con_valid}, 32'h0);
      reset = 1'b1;
      rd("status_after_rst", STATUS, 32'h0000_0001);

      // RAM store, load and alias
      wr(32'h10, 32'hDEAD_BEEF);
      rd("ram_load", 32'h10, 32'hDEAD_BEEF);
      rd("ram_alias", 32'h10 + 32'd256, 32'hDEAD_BEEF);
      wr(32'h14, 32'h0123_4567);
      rd("ram_neighbor", 32'h14, 32'h0123_4567);
      rd("ram_keep", 32'h10, 32'hDEAD_BEEF);

      // Overfill the FIFO with the sink stalled
      for (int i = 0; i < 5; i++) wr(CON_TX, 32'h41 + 32'(i));
      rd("status_ovf", STATUS, 32'h0000_0406);
      rd("con_tx_read", CON_TX, 32'h0);
      chk("head_A", {24'b0, con_data}, 32'h41);
      con_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("drain_valid", {31'b0, con_valid}, 32'h1);
         chk("drain_data", {24'b0, con_data}, 32'h41 + 32'(i));
         cyc();
      end
      chk("drained_valid", {31'b0, con_valid}, 32'h0);
      con_ready = 1'b0;
      rd("status_sticky", STATUS, 32'h0000_0005);
      wr(STATUS, 32'h4);
      rd("status_cleared", STATUS, 32'h0000_0001);

      // Push into a full FIFO while popping
      for (int i = 0; i < 4; i++) wr(CON_TX, 32'h41 + 32'(i));
      rd("status_full", STATUS, 32'h0000_0402);
      con_ready = 1'b1;
      wr(CON_TX, 32'h45);
      con_ready = 1'b0;
      rd("status_push_pop", STATUS, 32'h0000_0402);
      chk("head_B", {24'b0, con_data}, 32'h42);
      con_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("order_data", {24'b0, con_data}, 32'h42 + 32'(i));
         cyc();
      end
      chk("order_empty", {31'b0, con_valid}, 32'h0);
      con_ready = 1'b0;

      // CYCLE load and wrap
      wr(CYCLE, 32'hFFFF_FFFE);
      rd("cycle_loaded", CYCLE, 32'hFFFF_FFFE);
      cyc();
      rd("cycle_max", CYCLE, 32'hFFFF_FFFF);
      cyc();
      rd("cycle_wrap", CYCLE, 32'h0000_0000);

      // SCRATCH and unmapped offsets
      rd("scratch_rst", SCRATCH, 32'h0);
      wr(SCRATCH, 32'h1234_5678);
      rd("scratch_rw", SCRATCH, 32'h1234_5678);
      wr(IO + 32'h40, 32'hFFFF_FFFF);
      rd("unmapped", IO + 32'h40, 32'h0);
      rd("scratch_keep", SCRATCH, 32'h1234_5678);

      // Reset in the middle of a drain
      for (int i = 0; i < 3; i++) wr(CON_TX, 32'h61 + 32'(i));
      chk("mid_valid", {31'b0, con_valid}, 32'h1);
      con_ready = 1'b1;
      cyc();
      chk("mid_head", {24'b0, con_data}, 32'h62);
      aluout = STATUS;
      reset  = 1'b0;
      #1;
      chk("mid_rst_valid", {31'b0, con_valid}, 32'h0);
      chk("mid_rst_readdata", readdata, 32'h0);
      cyc();
      reset     = 1'b1;
      con_ready = 1'b0;
      rd("mid_rst_status", STATUS, 32'h0000_0001);
      rd("mid_rst_scratch", SCRATCH, 32'h0);
      rd("mid_rst_ram", 32'h10, 32'hDEAD_BEEF);
      cyc();
      chk("post_rst_valid", {31'b0, con_valid}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
